i2s_rate_switch_ctrl: RTL and testbench

I2S_RATE_SWITCH_CTRL -- requirements
Module: i2s_rate_switch_ctrl

---
 rtl/i2s_rate_switch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_i2s_rate_switch_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rate_switch_ctrl.sv
// Glitch-free I2S sample-rate switch sequencer: mute, drain frames, gate the
// clock, move the mux select, ungate, then unmute on a frame boundary.
module i2s_rate_switch_ctrl #(
  parameter int SEL_W         = 2,
  parameter int DRAIN_FRAMES  = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 1024
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic             frame_strobe,
  output logic [SEL_W-1:0] mux_sel,
  output logic             clk_en,
  output logic             mute,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUTE_WAIT,
    S_GATE,
    S_SWITCH,
    S_UNGATE,
    S_FINISH
  } state_t;

  localparam logic [3:0]  DRAIN_LAST   = 4'(DRAIN_FRAMES - 1);
  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(FRAME_TIMEOUT - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_pending_sel;
  logic [SEL_W-1:0] r_mux_sel;
  logic             r_clk_en;
  logic             r_mute;
  logic             r_done;
  logic             r_err;
  logic [3:0]       r_frame_cnt;
  logic [7:0]       r_settle_cnt;
  logic [15:0]      r_to_cnt;

  logic             w_to_hit;
  logic             w_settle_hit;

  // A strobe on the terminal count wins over the timeout.
  assign w_to_hit     = (r_to_cnt == TIMEOUT_LAST) && !frame_strobe;
  assign w_settle_hit = (r_settle_cnt == SETTLE_LAST);

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign mux_sel   = r_mux_sel;
  assign clk_en    = r_clk_en;
  assign mute      = r_mute;
  assign done      = r_done;
  assign err       = r_err;

  // NOTE: every register here is state, so all updates are non-blocking (<=);
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state       <= S_IDLE;
      r_pending_sel <= '0;
      r_mux_sel     <= '0;
      r_clk_en      <= 1'b1;
      r_mute        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_frame_cnt   <= '0;
      r_settle_cnt  <= '0;
      r_to_cnt      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_pending_sel <= req_sel;
            r_frame_cnt   <= '0;
            r_to_cnt      <= '0;
            if (req_sel == r_mux_sel) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_MUTE_WAIT;
              r_mute  <= 1'b1;
            end
          end
        end

        S_MUTE_WAIT: begin
          if (frame_strobe) begin
            r_to_cnt <= '0;
            if (r_frame_cnt == DRAIN_LAST) begin
              r_state      <= S_GATE;
              r_clk_en     <= 1'b0;
              r_settle_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 4'd1;
            end
          end else if (w_to_hit) begin
            r_err        <= 1'b1;
            r_state      <= S_GATE;
            r_clk_en     <= 1'b0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end

        S_GATE: begin
          if (w_settle_hit) begin
            r_state      <= S_SWITCH;
            r_mux_sel    <= r_pending_sel;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end

        S_SWITCH: begin
          if (w_settle_hit) begin
            r_state      <= S_UNGATE;
            r_clk_en     <= 1'b1;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end

        S_UNGATE: begin
          if (frame_strobe) begin
            r_state  <= S_FINISH;
            r_to_cnt <= '0;
          end else if (w_to_hit) begin
            r_err    <= 1'b1;
            r_state  <= S_FINISH;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end

        S_FINISH: begin
          r_mute  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rate_switch_ctrl.sv
// Directed bench for i2s_rate_switch_ctrl: vector table for the basic flows,
// hand-written sequences for timeout, mid-sequence reset and held requests.
module tb_i2s_rate_switch_ctrl;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       frame_strobe;
  logic [1:0] mux_sel;
  logic       clk_en;
  logic       mute;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  i2s_rate_switch_ctrl #(
    .SEL_W         (2),
    .DRAIN_FRAMES  (2),
    .SETTLE_CYCLES (4),
    .FRAME_TIMEOUT (64)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .frame_strobe (frame_strobe),
    .mux_sel      (mux_sel),
    .clk_en       (clk_en),
    .mute         (mute),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       valid;
    logic [1:0] sel;
    logic       strobe;
    logic [1:0] e_mux;
    logic       e_clk;
    logic       e_mute;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] e_mux, input logic e_clk,
                           input logic e_mute, input logic e_busy, input logic e_done,
                           input logic e_err);
    check({tag, ".mux_sel"},   32'(mux_sel),   32'(e_mux));
    check({tag, ".clk_en"},    32'(clk_en),    32'(e_clk));
    check({tag, ".mute"},      32'(mute),      32'(e_mute));
    check({tag, ".busy"},      32'(busy),      32'(e_busy));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(!e_busy));
    check({tag, ".done"},      32'(done),      32'(e_done));
    check({tag, ".err"},       32'(err),       32'(e_err));
  endtask

  // One clock: drive strobe for this cycle, then sample 1 time unit after the edge.
  task automatic step(input logic strobe);
    frame_strobe = strobe;
    @(posedge ACLK);
    #1;
    frame_strobe = 1'b0;
  endtask

  task automatic strobe_after(input int n);
    repeat (n - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic accept(input logic [1:0] sel);
    req_valid = 1'b1;
    req_sel   = sel;
    step(1'b0);
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    check_out({tag, ".rst"}, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0);
    check_out({tag, ".idle"}, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // The mux select may only move while the output clock is gated.
  logic [1:0] prev_mux = 2'd0;
  logic       prev_clk = 1'b0;
  always @(negedge ACLK) begin
    if (!ARESET && mux_sel !== prev_mux) begin
      checks++;
      if (prev_clk !== 1'b0) begin
        failures++;
        $display("FAIL mux_while_clk: mux_sel %0d -> %0d with clk_en=%0b", prev_mux, mux_sel, prev_clk);
      end
    end
    prev_mux = mux_sel;
    prev_clk = clk_en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET       = 1'b1;
    req_valid    = 1'b0;
    req_sel      = 2'd0;
    frame_strobe = 1'b0;

    //            valid sel  strb  mux   clk   mute  busy  done  err
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // same sel -> FINISH
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // done pulse
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // switch to 1, mute
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // frame 1
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // frame 2 -> GATE
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // strobes ignored
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // SWITCH
    tbl[11] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // UNGATE
    tbl[15] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // FINISH
    tbl[17] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // done, unmuted
    tbl[18] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    do_reset("reset0");

    for (int i = 0; i < 19; i++) begin
      req_valid = tbl[i].valid;
      req_sel   = tbl[i].sel;
      step(tbl[i].strobe);
      check_out($sformatf("vec%0d", i), tbl[i].e_mux, tbl[i].e_clk, tbl[i].e_mute,
                tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err);
    end
    req_valid = 1'b0;

    // Realistic frame spacing: strobes every 20 cycles, switch 0 -> 2.
    do_reset("reset1");
    accept(2'd2);
    check_out("slow.accept", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    strobe_after(20);
    check_out("slow.frame1", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    strobe_after(20);
    check_out("slow.gate", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0);
    check_out("slow.gate_end", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("slow.switch", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0);
    check_out("slow.switch_end", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("slow.ungate", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (19) step(1'b0);
    check_out("slow.ungate_wait", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    check_out("slow.finish", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("slow.done", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // No strobes at all: both waits time out after 64 cycles, switch 2 -> 1.
    accept(2'd1);
    check_out("to.accept", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (63) step(1'b0);
    check_out("to.mw_last", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("to.mw_err", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0);
    check_out("to.gate_end", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("to.switch", 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0);
    check_out("to.switch_end", 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("to.ungate", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (63) step(1'b0);
    check_out("to.ug_last", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("to.ug_err", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0);
    check_out("to.done", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-SWITCH, switch 1 -> 3.
    accept(2'd3);
    check_out("rs.accept", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    step(1'b1);
    check_out("rs.gate", 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0);
    check_out("rs.switch", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    #2;
    ARESET = 1'b1;
    #1;
    check_out("rs.async", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step((i % 3) == 2);
      check_out($sformatf("rs.after%0d", i), 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Request for 3 held through a 0 -> 2 sequence: taken only after FINISH.
    accept(2'd2);
    check_out("hold.accept", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_sel   = 2'd3;
    step(1'b1);
    step(1'b1);
    check_out("hold.gate", 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0);
    check_out("hold.switch", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0);
    check_out("hold.ungate", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    check_out("hold.finish", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    check_out("hold.idle", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0);
    check_out("hold.accept2", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    req_valid = 1'b0;
    step(1'b1);
    step(1'b1);
    check_out("hold.gate2", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0);
    check_out("hold.switch2", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0);
    check_out("hold.ungate2", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    step(1'b0);
    check_out("hold.done2", 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
